// File: rtl/axi_err_pkg.sv
// rtl/axi_err_pkg.sv - shared types and parameter defaults for the AXI error slave
// Contents: resp_t (AXI response codes), burst_t (AXI burst types), DEF_* defaults.
package axi_err_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam int         DEF_ID_W   = 8;
  localparam int         DEF_ADDR_W = 32;
  localparam int         DEF_DATA_W = 32;
  localparam int         DEF_LEN_W  = 4;
  localparam int         DEF_DEPTH  = 2;
  localparam logic [1:0] DEF_RESP   = RESP_DECERR;

endpackage

// File: rtl/axi_err_fifo.sv
// rtl/axi_err_fifo.sv - small synchronous FIFO used for the AR, AW and B queues
// Ports: clk, rst (async, active-high); push/din write side; pop read side;
//        full/empty status; head = oldest entry (zero when empty after reset).
// A push while full or a pop while empty is ignored.
module axi_err_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  // DEPTH = 1 still needs a 1-bit pointer; it simply never advances.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = din;
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_err_slave.sv
// rtl/axi_err_slave.sv - AXI default slave answering every burst with an error code
// Ports: ACLK, ARESET (async, active-high); AR/R read channels; AW/W/B write
//        channels; proto_err = sticky flag for WLAST not matching AWLEN.
// Read bursts are returned at full length with RDATA = 0; each write burst gets
// one B response. Addresses, sizes, burst types and write data are ignored.
module axi_err_slave
  import axi_err_pkg::*;
#(
  parameter int         ID_W   = DEF_ID_W,
  parameter int         ADDR_W = DEF_ADDR_W,
  parameter int         DATA_W = DEF_DATA_W,
  parameter int         LEN_W  = DEF_LEN_W,
  parameter int         DEPTH  = DEF_DEPTH,
  parameter logic [1:0] RESP   = DEF_RESP
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic                proto_err
);

  logic                   ar_full, ar_empty, aw_full, aw_empty, b_full, b_empty;
  logic [ID_W+LEN_W-1:0]  ar_head, aw_head;
  logic [ID_W-1:0]        ar_id, aw_id;
  logic [LEN_W-1:0]       ar_len, aw_len;
  logic                   ar_push, ar_pop, aw_push, w_hs, w_end, r_hs;
  logic [LEN_W-1:0]       rbeat_q, rbeat_d, wbeat_q, wbeat_d;
  logic                   proto_err_q, proto_err_d;
  logic                   unused_inputs;

  assign unused_inputs = ^{ARADDR, ARSIZE, ARBURST, AWADDR, AWSIZE, AWBURST, WDATA, WSTRB};

  // Read path
  assign ARREADY = !ARESET && !ar_full;
  assign ar_push = ARVALID && ARREADY;
  assign {ar_id, ar_len} = ar_head;
  assign RVALID  = !ar_empty;
  assign RID     = ar_id;
  assign RDATA   = '0;
  assign RRESP   = RESP;
  assign RLAST   = RVALID && (rbeat_q == ar_len);
  assign r_hs    = RVALID && RREADY;
  assign ar_pop  = r_hs && RLAST;

  axi_err_fifo #(.WIDTH(ID_W + LEN_W), .DEPTH(DEPTH)) u_ar_q (
    .clk(ACLK), .rst(ARESET), .push(ar_push), .din({ARID, ARLEN}), .pop(ar_pop),
    .full(ar_full), .empty(ar_empty), .head(ar_head)
  );

  // Write path: W beats are only taken when their AW is known and a B slot is free,
  // so the B push on WLAST can never be dropped.
  assign AWREADY = !ARESET && !aw_full;
  assign aw_push = AWVALID && AWREADY;
  assign {aw_id, aw_len} = aw_head;
  assign WREADY  = !aw_empty && !b_full;
  assign w_hs    = WVALID && WREADY;
  assign w_end   = w_hs && WLAST;

  axi_err_fifo #(.WIDTH(ID_W + LEN_W), .DEPTH(DEPTH)) u_aw_q (
    .clk(ACLK), .rst(ARESET), .push(aw_push), .din({AWID, AWLEN}), .pop(w_end),
    .full(aw_full), .empty(aw_empty), .head(aw_head)
  );

  axi_err_fifo #(.WIDTH(ID_W), .DEPTH(DEPTH)) u_b_q (
    .clk(ACLK), .rst(ARESET), .push(w_end), .din(aw_id), .pop(BVALID && BREADY),
    .full(b_full), .empty(b_empty), .head(BID)
  );

  assign BVALID    = !b_empty;
  assign BRESP     = RESP;
  assign proto_err = proto_err_q;

  always_comb begin
    rbeat_d = rbeat_q;
    if (r_hs) rbeat_d = RLAST ? '0 : rbeat_q + 1'b1;
    wbeat_d = wbeat_q;
    if (w_hs) wbeat_d = WLAST ? '0 : wbeat_q + 1'b1;
    // Flag both an early WLAST and a missing WLAST on the expected final beat.
    proto_err_d = proto_err_q || (w_hs && (WLAST != (wbeat_q == aw_len)));
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rbeat_q     <= '0;
      wbeat_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rbeat_q     <= rbeat_d;
      wbeat_q     <= wbeat_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule
